// File: rtl/dcmi_capture_ctrl.sv
// DCMI-style camera capture controller.
// Qualifies pixels from a parallel camera bus by vsync/hsync and an optional
// crop window. It can drop whole frames to reduce the frame rate. Accepted
// pixels go into a one-entry ready/valid holding register.
module dcmi_capture_ctrl #(
  parameter int PW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic          cfg_stop,
  input  logic          cfg_snapshot,
  input  logic          cfg_vsync_pol,
  input  logic          cfg_hsync_pol,
  input  logic          cfg_crop_en,
  input  logic [13:0]   cfg_crop_vst,
  input  logic [13:0]   cfg_crop_hst,
  input  logic [13:0]   cfg_crop_vlen,
  input  logic [13:0]   cfg_crop_hlen,
  input  logic [1:0]    cfg_skip,
  input  logic          vsync,
  input  logic          hsync,
  input  logic          pix_vld,
  input  logic [PW-1:0] pix_data,
  input  logic          out_rdy,
  output logic          out_vld,
  output logic [PW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eol,
  output logic          capture_en,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          ovr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FRAME = 2'd2,
    SKIP  = 2'd3
  } state_t;

  state_t state_r, state_nxt_s;

  logic        vs_prev_r, hs_prev_r;
  logic        vs_act_s, hs_act_s;
  logic        vs_rise_s, vs_fall_s, hs_rise_s, hs_fall_s;
  logic        stop_pend_r, stop_eff_s;
  logic [1:0]  skip_cnt_r;
  logic        snap_r, crop_en_r;
  logic [13:0] crop_vst_r, crop_hst_r, crop_vlen_r, crop_hlen_r;
  logic [1:0]  skip_mode_r;
  logic [13:0] line_cnt_r, pix_cnt_r, pix_idx_s, pix_nxt_s;
  logic        first_r;
  logic        start_ok_s, arm_go_s, frame_start_s, frame_end_s;
  logic [14:0] v_end_s, h_end_s;
  logic        in_win_s, accept_s, eol_hit_s;

  // Next skip counter value. The modulus is 1, 2 or 4 depending on the rate setting.
  function automatic logic [1:0] skip_inc(input logic [1:0] cnt, input logic [1:0] mode);
    logic [1:0] res;
    case (mode)
      2'b00:   res = 2'd0;
      2'b01:   res = {1'b0, ~cnt[0]};
      default: res = cnt + 2'd1;
    endcase
    return res;
  endfunction

  assign vs_act_s   = cfg_vsync_pol ? vsync : ~vsync;
  assign hs_act_s   = cfg_hsync_pol ? hsync : ~hsync;
  assign vs_rise_s  = vs_act_s & ~vs_prev_r;
  assign vs_fall_s  = ~vs_act_s & vs_prev_r;
  assign hs_rise_s  = hs_act_s & ~hs_prev_r;
  assign hs_fall_s  = ~hs_act_s & hs_prev_r;
  assign stop_eff_s = stop_pend_r | cfg_stop;

  // State transitions and the single-cycle control events they produce.
  always_comb begin
    state_nxt_s   = state_r;
    start_ok_s    = 1'b0;
    arm_go_s      = 1'b0;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cfg_start && !cfg_stop) begin
          state_nxt_s = ARMED;
          start_ok_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED: begin
        if (cfg_stop) begin
          state_nxt_s = IDLE;
        end else if (vs_rise_s) begin
          arm_go_s = 1'b1;
          if (skip_cnt_r == 2'd0) begin
            state_nxt_s   = FRAME;
            frame_start_s = 1'b1;
          end else begin
            state_nxt_s = SKIP;
          end
        end else begin
          state_nxt_s = ARMED;
        end
      end
      FRAME: begin
        if (vs_fall_s) begin
          frame_end_s = 1'b1;
          state_nxt_s = (snap_r || stop_eff_s) ? IDLE : ARMED;
        end else begin
          state_nxt_s = FRAME;
        end
      end
      SKIP: begin
        if (vs_fall_s) begin
          state_nxt_s = stop_eff_s ? IDLE : ARMED;
        end else begin
          state_nxt_s = SKIP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Crop window test. The sums are 15 bits wide so a window end beyond 14 bits does not wrap.
  always_comb begin
    pix_idx_s = hs_rise_s ? 14'd0 : pix_cnt_r;
    pix_nxt_s = (pix_vld && hs_act_s) ? (pix_idx_s + 14'd1) : pix_idx_s;
    v_end_s   = {1'b0, crop_vst_r} + {1'b0, crop_vlen_r};
    h_end_s   = {1'b0, crop_hst_r} + {1'b0, crop_hlen_r};
    if (crop_en_r) begin
      in_win_s = (line_cnt_r >= crop_vst_r) && ({1'b0, line_cnt_r} < v_end_s) &&
                 (pix_idx_s >= crop_hst_r) && ({1'b0, pix_idx_s} < h_end_s);
    end else begin
      in_win_s = 1'b1;
    end
    eol_hit_s = crop_en_r && ({1'b0, pix_idx_s} == (h_end_s - 15'd1));
    accept_s  = (state_r == FRAME) && hs_act_s && pix_vld && in_win_s;
  end

  // State, counters, latched configuration and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      vs_prev_r   <= 1'b0;
      hs_prev_r   <= 1'b0;
      stop_pend_r <= 1'b0;
      skip_cnt_r  <= 2'd0;
      snap_r      <= 1'b0;
      crop_en_r   <= 1'b0;
      crop_vst_r  <= 14'd0;
      crop_hst_r  <= 14'd0;
      crop_vlen_r <= 14'd0;
      crop_hlen_r <= 14'd0;
      skip_mode_r <= 2'd0;
      line_cnt_r  <= 14'd0;
      pix_cnt_r   <= 14'd0;
      first_r     <= 1'b0;
      out_vld     <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      capture_en  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= 16'd0;
      ovr_err     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      vs_prev_r  <= vs_act_s;
      hs_prev_r  <= hs_act_s;
      capture_en <= (state_nxt_s != IDLE);
      busy       <= (state_nxt_s != IDLE);
      frame_done <= frame_end_s;
      if (frame_end_s) frame_cnt <= frame_cnt + 16'd1;

      if (state_nxt_s == IDLE) begin
        stop_pend_r <= 1'b0;
      end else if (cfg_stop && ((state_r == FRAME) || (state_r == SKIP))) begin
        stop_pend_r <= 1'b1;
      end

      if (arm_go_s) begin
        skip_cnt_r  <= skip_inc(skip_cnt_r, cfg_skip);
        skip_mode_r <= cfg_skip;
        snap_r      <= cfg_snapshot;
        crop_en_r   <= cfg_crop_en;
        crop_vst_r  <= cfg_crop_vst;
        crop_hst_r  <= cfg_crop_hst;
        crop_vlen_r <= cfg_crop_vlen;
        crop_hlen_r <= cfg_crop_hlen;
      end

      if (frame_start_s) begin
        line_cnt_r <= 14'd0;
      end else if ((state_r == FRAME) && hs_fall_s) begin
        line_cnt_r <= line_cnt_r + 14'd1;
      end
      pix_cnt_r <= pix_nxt_s;

      // The start-of-frame marker goes to the first accepted pixel, even if that pixel is dropped.
      if (frame_start_s) begin
        first_r <= 1'b1;
      end else if (accept_s) begin
        first_r <= 1'b0;
      end

      if (start_ok_s) begin
        ovr_err <= 1'b0;
      end else if (accept_s && out_vld && !out_rdy) begin
        ovr_err <= 1'b1;
      end

      if (accept_s && (!out_vld || out_rdy)) begin
        out_vld  <= 1'b1;
        out_data <= pix_data;
        out_sof  <= first_r;
        out_eol  <= eol_hit_s;
      end else if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
        out_sof <= 1'b0;
        out_eol <= 1'b0;
      end
    end
  end

endmodule
